// File: rtl/pixel_stream_reader_if.sv
// Bus bundle of pixel_stream_reader: pixel FIFO read port plus AXI4-Stream pixel output.
// Latency: none, wires only.
// Backpressure: carries m_axis_tready from the sink back to the reader.
// Ports (master = reader side):
//   fifo_empty, fifo_data (in); fifo_read_en (out)
//   m_axis_tready (in); m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_pixel (out)
// The slave modport is the mirror image, used by the FIFO/sink side.
interface pixel_stream_reader_if #(
    parameter int DATA_WIDTH = 20,
    parameter int X_WIDTH    = 10
);
    logic                          fifo_empty;
    logic                          fifo_read_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [DATA_WIDTH-X_WIDTH-1:0] m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tuser;
    logic                          m_axis_tlast;
    logic                          err_pixel;

    modport master (
        input  fifo_empty, fifo_data, m_axis_tready,
        output fifo_read_en, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_pixel
    );

    modport slave (
        output fifo_empty, fifo_data, m_axis_tready,
        input  fifo_read_en, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, err_pixel
    );
endinterface

// File: rtl/pixel_stream_reader.sv
// Reorders out-of-order {x, depth} FIFO entries through a one-line buffer into a raster AXI4-Stream.
// Latency: pop in C, capture in C+1, output register loads end of C+2, tvalid in C+3.
// Backpressure: tready low fills the line buffer, then the hold register, then stops popping.
// Ports: clk, reset (async, active-high); bus (pixel_stream_reader_if.master): FIFO read port,
//        m_axis_* stream with tuser = first pixel of frame, tlast = last pixel of line, err_pixel.
// Optional feature: define PIXEL_READER_ERR_EN to drop entries with x >= LINE_WIDTH and pulse
//        err_pixel; without it err_pixel is tied low and x must be in range.
module pixel_stream_reader #(
    parameter int DATA_WIDTH   = 20,
    parameter int X_WIDTH      = 10,
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_stream_reader_if.master bus
);
    localparam int DEPTH_W = DATA_WIDTH - X_WIDTH;
    localparam int IDX_W   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LINE_W  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [X_WIDTH-1:0] X_LAST    = X_WIDTH'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(FRAME_HEIGHT - 1);

    // Line buffer: depth storage has no reset, the valid bits alone say what is live.
    logic [DEPTH_W-1:0]    mem [LINE_WIDTH];
    logic [LINE_WIDTH-1:0] valid;

    logic                  hold_valid;
    logic [IDX_W-1:0]      hold_idx;
    logic [DEPTH_W-1:0]    hold_depth;
    logic                  rd_inflight;
    logic [X_WIDTH-1:0]    out_x;
    logic [LINE_W-1:0]     out_line;

    logic [DEPTH_W-1:0]    tdata_q;
    logic                  tvalid_q;
    logic                  tuser_q;
    logic                  tlast_q;

    logic [X_WIDTH-1:0]    in_x;
    logic [DEPTH_W-1:0]    in_depth;
    logic [IDX_W-1:0]      in_idx;
    logic [IDX_W-1:0]      out_idx;
    logic                  in_range;
    logic                  emit;
    logic                  collision;
    logic                  cap_wr;
    logic                  cap_hold;
    logic                  hold_wr;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DEPTH_W-1:0]    wr_depth;

    assign in_x     = bus.fifo_data[DATA_WIDTH-1 -: X_WIDTH];
    assign in_depth = bus.fifo_data[DEPTH_W-1:0];
    assign in_idx   = in_x[IDX_W-1:0];
    assign out_idx  = out_x[IDX_W-1:0];

`ifdef PIXEL_READER_ERR_EN
    // Compare one bit wider so LINE_WIDTH == 2**X_WIDTH does not wrap to zero.
    localparam logic [X_WIDTH:0] LINE_LIMIT = (X_WIDTH + 1)'(LINE_WIDTH);
    assign in_range      = ({1'b0, in_x} < LINE_LIMIT);
    assign bus.err_pixel = rd_inflight && !in_range;
`else
    logic unused_x_bits;
    assign unused_x_bits = ^in_x;
    assign in_range      = 1'b1;
    assign bus.err_pixel = 1'b0;
`endif

    // The slot at out_x frees up this cycle when its pixel moves into the output register.
    assign emit = valid[out_idx] && (!tvalid_q || bus.m_axis_tready);

    // A slot that is being emitted this cycle counts as free: the new write wins over the clear.
    assign collision = valid[in_idx] && !(emit && (out_idx == in_idx));
    assign cap_wr    = rd_inflight && in_range && !collision;
    assign cap_hold  = rd_inflight && in_range && collision;
    assign hold_wr   = hold_valid && !(valid[hold_idx] && !(emit && (out_idx == hold_idx)));

    // A held entry blocks popping, so capture and hold retry never write in the same cycle.
    assign wr_en    = cap_wr || hold_wr;
    assign wr_idx   = cap_wr ? in_idx : hold_idx;
    assign wr_depth = cap_wr ? in_depth : hold_depth;

    assign bus.fifo_read_en = !reset && !bus.fifo_empty && !hold_valid && !cap_hold;

    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign bus.m_axis_tlast  = tlast_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_depth;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            hold_valid  <= 1'b0;
            hold_idx    <= '0;
            hold_depth  <= '0;
            rd_inflight <= 1'b0;
            out_x       <= '0;
            out_line    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            rd_inflight <= bus.fifo_read_en;

            if (emit) begin
                valid[out_idx] <= 1'b0;
                tdata_q        <= mem[out_idx];
                tvalid_q       <= 1'b1;
                tuser_q        <= (out_x == '0) && (out_line == '0);
                tlast_q        <= (out_x == X_LAST);
                if (out_x == X_LAST) begin
                    out_x    <= '0;
                    out_line <= (out_line == LINE_LAST) ? '0 : out_line + LINE_W'(1);
                end else begin
                    out_x <= out_x + X_WIDTH'(1);
                end
            end else if (bus.m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            // Placed after the emit clear so a same-slot write keeps the bit set.
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end

            if (cap_hold) begin
                hold_valid <= 1'b1;
                hold_idx   <= in_idx;
                hold_depth <= in_depth;
            end else if (hold_wr) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench for pixel_stream_reader: FIFO model feeds entries, scoreboard checks stream beats.
// Latency: FIFO model returns popped data on the edge after the pop.
// Backpressure: tready driven by the stimulus thread.
`timescale 1ns/1ps
module tb_pixel_stream_reader;
    localparam int DATA_WIDTH   = 20;
    localparam int X_WIDTH      = 10;
    localparam int LINE_WIDTH   = 4;
    localparam int FRAME_HEIGHT = 2;
    localparam int DW           = DATA_WIDTH - X_WIDTH;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pixel_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH), .X_WIDTH(X_WIDTH)) bus ();

    pixel_stream_reader #(
        .DATA_WIDTH  (DATA_WIDTH),
        .X_WIDTH     (X_WIDTH),
        .LINE_WIDTH  (LINE_WIDTH),
        .FRAME_HEIGHT(FRAME_HEIGHT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int beats    = 0;
    int err_cnt  = 0;
    int pop0_cyc = -1;

    logic [DATA_WIDTH-1:0] fq[$];
    beat_t                 exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int d);
        fq.push_back({X_WIDTH'(x), DW'(d)});
    endtask

    task automatic expect_beat(input int d, input logic u, input logic l);
        beat_t b;
        b.dat  = DW'(d);
        b.user = u;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && (exp_q.size() != 0 || bus.m_axis_tvalid); i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        fq.delete();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Registered-output FIFO: data appears on the edge after the accepted pop.
    always @(posedge clk) begin : fifo_model
        logic [DATA_WIDTH-1:0] e;
        if (bus.fifo_read_en && fq.size() > 0) begin
            e = fq.pop_front();
            pops++;
            if (pop0_cyc < 0 && e[DATA_WIDTH-1 -: X_WIDTH] == '0) pop0_cyc = cyc;
            bus.fifo_data <= e;
        end
        cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard for every accepted beat.
    always @(negedge clk) begin : monitor
        beat_t exp_b;
        bus.fifo_empty = (fq.size() == 0);
        if (bus.err_pixel) err_cnt++;
        if (!reset && bus.m_axis_tvalid && bus.m_axis_tready) begin
            beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data=%0d user=%0b last=%0b, expected no beat",
                         bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast);
            end else begin
                exp_b = exp_q.pop_front();
                if ({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast} !== exp_b) begin
                    n_fail++;
                    $display("FAIL beat %0d: got data=%0d user=%0b last=%0b, expected data=%0d user=%0b last=%0b",
                             beats, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast,
                             exp_b.dat, exp_b.user, exp_b.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int base;
        logic seen33;
        logic held_rd;

        bus.fifo_empty    = 1'b1;
        bus.fifo_data     = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_tdata",  bus.m_axis_tdata, 0);
        check("rst_tuser",  bus.m_axis_tuser, 0);
        check("rst_tlast",  bus.m_axis_tlast, 0);
        check("rst_rd_en",  bus.fifo_read_en, 0);
        check("rst_err",    bus.err_pixel, 0);
        reset = 1'b0;
        tick();

        // Out-of-order line
        bus.m_axis_tready = 1'b1;
        pop0_cyc = -1;
        push(2, 5); push(0, 7); push(3, 9); push(1, 11);
        expect_beat(7, 1, 0); expect_beat(11, 0, 0); expect_beat(5, 0, 0); expect_beat(9, 0, 1);
        rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid) rise = cyc;
        end
        check("t1_latency", rise - pop0_cyc, 3);
        wait_drain("t1_drain", 40);

        // Frame wrap across three in-order lines: tuser on beats 1 and 9, tlast every 4th
        do_reset();
        bus.m_axis_tready = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int x = 0; x < 4; x++) begin
                push(x, l * 4 + x);
                expect_beat(l * 4 + x, (x == 0) && (l != 1), x == 3);
            end
        end
        wait_drain("t2_drain", 60);

        // Backpressure during line 0
        do_reset();
        bus.m_axis_tready = 1'b0;
        base = pops;
        for (int i = 0; i < 8; i++) push(i % 4, 20 + i);
        expect_beat(20, 1, 0); expect_beat(21, 0, 0); expect_beat(22, 0, 0); expect_beat(23, 0, 1);
        expect_beat(24, 0, 0); expect_beat(25, 0, 0); expect_beat(26, 0, 0); expect_beat(27, 0, 1);
        for (int i = 0; i < 20 && !bus.m_axis_tvalid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_stable", {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast},
                  {1'b1, DW'(20), 1'b1, 1'b0});
        end
        check("t3_pops", pops - base, 6);
        check("t3_rd_en_stalled", bus.fifo_read_en, 0);
        bus.m_axis_tready = 1'b1;
        wait_drain("t3_drain", 60);

        // Next-line x=3 collides with the pending line 0 x=3
        do_reset();
        bus.m_axis_tready = 1'b0;
        base = pops;
        push(0, 30); push(1, 31); push(2, 32); push(3, 33); push(3, 37);
        expect_beat(30, 1, 0); expect_beat(31, 0, 0); expect_beat(32, 0, 0); expect_beat(33, 0, 1);
        expect_beat(34, 0, 0); expect_beat(35, 0, 0); expect_beat(36, 0, 0); expect_beat(37, 0, 1);
        repeat (12) tick();
        check("t4_pops", pops - base, 5);
        push(0, 34); push(1, 35); push(2, 36);
        repeat (3) tick();
        check("t4_rd_en_held", bus.fifo_read_en, 0);
        bus.m_axis_tready = 1'b1;
        seen33  = 1'b0;
        held_rd = 1'b0;
        for (int i = 0; i < 30 && !seen33; i++) begin
            tick();
            if (bus.m_axis_tvalid && bus.m_axis_tdata == DW'(33)) seen33 = 1'b1;
            if (!seen33 && bus.fifo_read_en) held_rd = 1'b1;
        end
        check("t4_seen_x3", seen33, 1);
        check("t4_rd_while_held", held_rd, 0);
        wait_drain("t4_drain", 60);

`ifdef PIXEL_READER_ERR_EN
        // Out-of-range x is dropped with a single err pulse
        do_reset();
        bus.m_axis_tready = 1'b1;
        base = err_cnt;
        push(0, 1); push(6, 3); push(1, 2); push(2, 4); push(3, 5);
        expect_beat(1, 1, 0); expect_beat(2, 0, 0); expect_beat(4, 0, 0); expect_beat(5, 0, 1);
        wait_drain("t5_drain", 60);
        check("t5_err_pulses", err_cnt - base, 1);
`else
        check("err_tied_low", err_cnt, 0);
`endif

        // Asynchronous reset mid-line
        do_reset();
        bus.m_axis_tready = 1'b1;
        base = beats;
        push(0, 40); push(1, 41); push(2, 42); push(3, 43);
        expect_beat(40, 1, 0); expect_beat(41, 0, 0); expect_beat(42, 0, 0); expect_beat(43, 0, 1);
        for (int i = 0; i < 30 && (beats - base) < 2; i++) tick();
        check("t6_two_beats", beats - base, 2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_tvalid", bus.m_axis_tvalid, 0);
        check("t6_rst_tdata",  bus.m_axis_tdata, 0);
        check("t6_rst_tuser",  bus.m_axis_tuser, 0);
        check("t6_rst_tlast",  bus.m_axis_tlast, 0);
        check("t6_rst_rd_en",  bus.fifo_read_en, 0);
        fq.delete();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        push(0, 50); push(1, 51); push(2, 52); push(3, 53);
        expect_beat(50, 1, 0); expect_beat(51, 0, 0); expect_beat(52, 0, 0); expect_beat(53, 0, 1);
        wait_drain("t6_drain", 40);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
